// File: rtl/io_display_scan.sv
// io_display_scan: output-port display stage.
// Shift-add-3 BCD conversion per port, 8-digit seven-segment scan.
module io_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        busy
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, COMMIT
  } state_t;

  state_t state, state_nx;

  logic          sel;
  logic [15:0]   snap, bin, bcd, adj;
  logic [3:0]    cnt;
  logic [15:0]   shown [2];
  logic [1:0]    valid;
  logic [3:0]    disp [8];
  logic [3:0]    sym [4];
  logic [CW-1:0] scnt;
  logic [2:0]    idx, idx_nx;
  logic          pend0, pend1;
  logic          unused_hi;

  assign unused_hi = ^{out_port0[31:16], out_port1[31:16]};

  assign pend0 = !valid[0] || (out_port0[15:0] != shown[0]);
  assign pend1 = !valid[1] || (out_port1[15:0] != shown[1]);

  // symbols: 0-9 digits, A dash, F blank
  function automatic logic [7:0] seg_code(input logic [3:0] s);
    logic [7:0] c;
    case (s)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      4'hA:    c = 8'hBF;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  always_ff @(posedge clock) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pend0 || pend1) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (cnt == 4'd15) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) sym[i] = bcd[4*i +: 4];
    if (snap > 16'd9999) begin
      for (int i = 0; i < 4; i++) sym[i] = 4'hA;
    end else if (BLANK_LZ) begin
      if (bcd[15:12] == 4'd0) sym[3] = 4'hF;
      if (bcd[15:8] == 8'd0)  sym[2] = 4'hF;
      if (bcd[15:4] == 12'd0) sym[1] = 4'hF;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      sel   <= 1'b0;
      snap  <= '0;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      valid <= '0;
      shown[0] <= '0;
      shown[1] <= '0;
      for (int i = 0; i < 8; i++) disp[i] <= 4'd0;
    end else begin
      unique case (state)
        IDLE: sel <= !pend0;
        LOAD: begin
          snap <= sel ? out_port1[15:0] : out_port0[15:0];
          bin  <= sel ? out_port1[15:0] : out_port0[15:0];
          bcd  <= '0;
          cnt  <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt <= cnt + 4'd1;
        end
        COMMIT: begin
          for (int i = 0; i < 4; i++) begin
            if (sel) disp[i+4] <= sym[i];
            else     disp[i]   <= sym[i];
          end
          shown[sel] <= snap;
          valid[sel] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign idx_nx = idx + 3'd1;

  // seg_n samples the display only on slot change, so a slot never glitches
  always_ff @(posedge clock) begin
    if (clr) begin
      scnt  <= '0;
      idx   <= '0;
      an_n  <= 8'hFE;
      seg_n <= 8'hC0;
    end else if (scnt == CW'(SCAN_DIV - 1)) begin
      scnt  <= '0;
      idx   <= idx_nx;
      an_n  <= ~(8'd1 << idx_nx);
      seg_n <= seg_code(disp[idx_nx]);
    end else begin
      scnt <= scnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_io_display_scan.sv
// tb_io_display_scan: directed stimulus, cycle-level behavioural model,
// blanking and non-blanking instances compared every cycle.
module tb_io_display_scan;

  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] out_port0 = '0;
  logic [31:0] out_port1 = '0;
  logic [7:0]  seg1, an1, seg2, an2;
  logic        busy1, busy2;

  io_display_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clock(clock), .clr(clr),
    .out_port0(out_port0), .out_port1(out_port1),
    .seg_n(seg1), .an_n(an1), .busy(busy1)
  );

  io_display_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
    .clock(clock), .clr(clr),
    .out_port0(out_port0), .out_port1(out_port1),
    .seg_n(seg2), .an_n(an2), .busy(busy2)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic mon_on = 1'b0;

  localparam logic [7:0] CODES [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  int P10 [4] = '{1, 10, 100, 1000};

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // model state: [0] = blanking instance, [1] = non-blanking instance
  int          t, age, mport, v;
  logic [15:0] msnap;
  logic        mvalid [2];
  logic [15:0] mshown [2];
  logic [7:0]  mseg [2][8];
  logic [7:0]  ean;
  logic [7:0]  eseg [2];
  logic        ebusy;

  initial begin
    forever begin
      @(posedge clock);
      if (clr) begin
        t = 0; age = 0; mport = 0; msnap = '0;
        for (int p = 0; p < 2; p++) begin
          mvalid[p] = 1'b0;
          mshown[p] = '0;
          eseg[p] = 8'hC0;
          for (int d = 0; d < 8; d++) mseg[p][d] = 8'hC0;
        end
        ean = 8'hFE;
      end else begin
        t++;
        if (t % SD == 0) begin
          ean = ~(8'd1 << ((t / SD) % 8));
          for (int p = 0; p < 2; p++) eseg[p] = mseg[p][(t / SD) % 8];
        end
        if (age == 0) begin
          if (!mvalid[0] || out_port0[15:0] != mshown[0]) begin
            age = 1; mport = 0;
          end else if (!mvalid[1] || out_port1[15:0] != mshown[1]) begin
            age = 1; mport = 1;
          end
        end else begin
          if (age == 1) msnap = mport ? out_port1[15:0] : out_port0[15:0];
          if (age == 18) begin
            v = int'(msnap);
            for (int i = 0; i < 4; i++) begin
              logic [7:0] c;
              c = (v > 9999) ? 8'hBF : CODES[(v / P10[i]) % 10];
              mseg[0][mport*4+i] = (v <= 9999 && i > 0 && v < P10[i]) ? 8'hFF : c;
              mseg[1][mport*4+i] = c;
            end
            mshown[mport] = msnap;
            mvalid[mport] = 1'b1;
            age = 0;
          end else begin
            age++;
          end
        end
      end
      ebusy = (age != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (mon_on) begin
        chk("busy", busy1, ebusy);
        chk("an", an1, ean);
        chk("seg", seg1, eseg[0]);
        chk("busy_nb", busy2, ebusy);
        chk("an_nb", an2, ean);
        chk("seg_nb", seg2, eseg[1]);
      end
    end
  end

  logic [7:0] cap [8];

  task automatic capture(input int j);
    logic [7:0] a, prev;
    int n;
    bit found, ok;
    prev = (j == 0) ? an1 : an2;
    n = 0; found = 0;
    while (!found && n < 16 * SD) begin
      @(negedge clock);
      a = (j == 0) ? an1 : an2;
      n++;
      found = (a == 8'hFE && prev != 8'hFE);
      prev = a;
    end
    chk("slot_found", found, 1);
    if (found) begin
      ok = 1;
      cap[0] = (j == 0) ? seg1 : seg2;
      for (int i = 1; i < 8; i++) begin
        repeat (SD) @(negedge clock);
        cap[i] = (j == 0) ? seg1 : seg2;
        a = (j == 0) ? an1 : an2;
        if (a != ~(8'd1 << i)) ok = 0;
      end
      chk("an_order", ok, 1);
    end
  endtask

  task automatic grp(input string n, input int j, input int base,
                     input logic [7:0] l3, l2, l1, l0);
    logic [7:0] lit [4];
    lit = '{l0, l1, l2, l3};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_d%0d", n, base + k), cap[base+k], lit[k]);
      chk($sformatf("%s_d%0d_model", n, base + k), mseg[j][base+k], lit[k]);
    end
  endtask

  task automatic count_busy(input int n, inout int c);
    repeat (n) begin
      @(negedge clock);
      c += int'(busy1);
    end
  endtask

  initial begin
    int c;
    logic last;
    clr = 1'b1;
    repeat (3) @(negedge clock);
    mon_on = 1'b1;
    clr = 1'b0;

    c = 0; count_busy(40, c);
    chk("t1_busy36", c, 36);
    capture(0);
    grp("t1", 0, 4, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    grp("t1", 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    capture(1);
    grp("t1nb", 1, 0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    out_port0 = 32'h0000_04D2;
    c = 0; last = 1'b0;
    repeat (19) begin
      @(negedge clock);
      c += int'(busy1);
      last = busy1;
    end
    chk("t2_busy18", c, 18);
    chk("t2_done", last, 0);
    capture(0);
    grp("t2", 0, 0, 8'hF9, 8'hA4, 8'hB0, 8'h99);
    grp("t2", 0, 4, 8'hFF, 8'hFF, 8'hFF, 8'hC0);

    out_port1 = 32'hFFFF_270F;
    repeat (25) @(negedge clock);
    capture(0);
    grp("t3", 0, 4, 8'h90, 8'h90, 8'h90, 8'h90);

    out_port0 = 32'd10000;
    repeat (25) @(negedge clock);
    capture(0);
    grp("t4", 0, 0, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    capture(1);
    grp("t4nb", 1, 0, 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    out_port0 = 32'd5;
    c = 0; count_busy(8, c);
    out_port0 = 32'd77;
    count_busy(40, c);
    chk("t5_busy36", c, 36);
    capture(0);
    grp("t5", 0, 0, 8'hFF, 8'hFF, 8'hF8, 8'hF8);

    out_port0 = 32'h0001_0005;
    repeat (25) @(negedge clock);
    out_port0 = 32'h0002_0005;
    c = 0; count_busy(30, c);
    chk("t6_nobusy", c, 0);
    capture(0);
    grp("t6", 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'h92);

    out_port0 = 32'd321;
    repeat (11) @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    chk("t7_busy", busy1, 0);
    chk("t7_an", an1, 8'hFE);
    chk("t7_seg", seg1, 8'hC0);
    @(negedge clock);
    clr = 1'b0;
    c = 0; count_busy(40, c);
    chk("t7_busy36", c, 36);
    capture(0);
    grp("t7", 0, 0, 8'hFF, 8'hB0, 8'hA4, 8'hF9);
    grp("t7", 0, 4, 8'h90, 8'h90, 8'h90, 8'h90);

    out_port1 = 32'd42;
    repeat (25) @(negedge clock);
    capture(1);
    grp("t8nb", 1, 4, 8'hC0, 8'hC0, 8'h99, 8'hA4);
    capture(0);
    grp("t8", 0, 4, 8'hFF, 8'hFF, 8'h99, 8'hA4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_display_scan.md
# io_display_scan

Memory-mapped output display stage for the 5-stage pipeline CPU. Consumes the two 32-bit output-port registers written by the data-memory/I/O stage (stores with address bit 7 set), converts the low 16 bits of each to decimal with an iterative shift-add-3 engine, and drives an 8-digit common-anode seven-segment display by time-multiplexed scanning. Port 1 appears on digits 7..4 and port 0 on digits 3..0.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range 2..2^20.
- BLANK_LZ, 1: 1 = blank leading zeros within each 4-digit group; digits 0 and 4 are never blanked.

- clock  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous and active-high.
- out_port0  in  32  output-port register 0; only [15:0] is displayed.
- out_port1  in  32  output-port register 1; only [15:0] is displayed.
- seg_n  out  8  active-low segments: [0]=a … [6]=g, [7]=dp; dp is always 1 (off).
- an_n  out  8  active-low digit enables; exactly one bit is 0 at all times.
- busy  out  1  high while a conversion is in progress.

## Operation
- Segment codes for 0–9: C0 F9 A4 B0 99 92 82 F8 80 90. Dash: BF. Blank: FF.
- Per-group state: a 4-digit display register, a 16-bit shown value, and a valid bit. Reset clears all valid bits and display digits to 0.
- Conversion FSM states are IDLE, LOAD, SHIFT and COMMIT.
  - IDLE: port 0 is pending if !valid0 or out_port0[15:0] != shown0; port 1 is pending likewise. If either is pending, go to LOAD. Port 0 has priority when both are pending.
  - LOAD: snapshot the selected port's 16 bits, clear the 16-bit BCD accumulator, and set the iteration count to 0.
  - SHIFT: runs exactly 16 cycles. Each cycle adds 3 to every BCD nibble that is ≥5, then shifts {bcd, bin} left by 1.
  - COMMIT: write the group's display register. If the snapshot is >9999, all four digits show dash. Otherwise apply BLANK_LZ. Then set shown to the snapshot, set valid, and return to IDLE.
- Only the snapshot is converted. A port change during SHIFT is caught by the compare in the next IDLE cycle and triggers reconversion.
- Bits [31:16] of each port are ignored. A change confined to those bits triggers no conversion.
- Scan counter runs 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→…→7→0.
  - an_n = ~(1<<idx).
  - seg_n is the code of display digit idx.
  - Both are registered and update on the same edge.
- Scanning is independent of conversion. The display register changes only at COMMIT, so a digit never shows a partial result.

## Timing
- Reset values: an_n=8'hFE, seg_n=8'hC0, busy=0, FSM=IDLE, scan counter=0, idx=0.
- First clock with clr=0: IDLE sees !valid0 and starts converting port 0. Port 1 converts immediately after.
- Latency: a pending condition present in IDLE at edge k →
  - LOAD at edge k+1;
  - SHIFT at edges k+2..k+17;
  - COMMIT at edge k+18, where the display register updates;
  - next IDLE at k+19.
- busy is high from edge k+1 through edge k+18, so it is high for 18 cycles.
- Both ports pending: port 1 commits 19 cycles after port 0.
- Display register to pins: the new digit appears when idx next selects it. This is at most 8·SCAN_DIV cycles after COMMIT.
- The scan wrap edge and a COMMIT edge may coincide. seg_n then uses the pre-COMMIT digit for one scan slot. No glitch is allowed within a slot.
- clr asserted mid-conversion aborts it. All state returns to reset values on that edge. Conversion restarts after release.

## Test plan
- Reset then settle.
  - Stimulus: clr high 3 cycles, ports=0; release; wait 40 cycles.
  - Required: busy high exactly 36 cycles total.
  - Required: digits 0 and 4 show C0 and all other digits FF (BLANK_LZ=1).
  - Required: an_n sequences FE,FD,FB,…,7F with each value held SCAN_DIV cycles (run with SCAN_DIV=4).
- Decimal conversion.
  - Stimulus: out_port0=32'h0000_04D2 (1234).
  - Required: digits 3..0 show F9 A4 B0 99 exactly 18 cycles after the change is sampled.
  - Stimulus: out_port1=32'hFFFF_270F.
  - Required: digits 7..4 show 90 90 90 90 (9999).
- Overflow and ignored bits.
  - Stimulus: out_port0=10000.
  - Required: digits 3..0 show BF ×4.
  - Stimulus: change out_port0 from 32'h0001_0005 to 32'h0002_0005.
  - Required: busy stays 0.
- Mid-conversion change.
  - Stimulus: set out_port0=5, then 8 cycles later set it to 77.
  - Required: 5 commits first, then 77 converts.
  - Required: the final digits 3..0 show FF FF F8 F8, with no other intermediate value.
- Reset during SHIFT.
  - Stimulus: assert clr at the 10th SHIFT cycle.
  - Required: on that edge busy=0, an_n=FE and seg_n=C0.
  - Required: after release, the full reconversion of both ports.
- Leading-zero option.
  - Stimulus: BLANK_LZ=0 with out_port1=42.
  - Required: digits 7..4 show C0 C0 99 A4.
